// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares one Wishbone-style bus between fetch and data ports,
//            with data priority, result holding, flush discard and timeout.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    input  logic        if_stall_i,
    output logic [31:0] if_data_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_data_i,
    input  logic        mem_stall_i,
    output logic [31:0] mem_data_o,
    output logic        mem_stallreq_o,
    input  logic        flush_i,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] C_CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_owner;
    logic           r_flushed;
    logic [CW-1:0]  r_cnt;
    logic [31:0]    r_result;

    logic w_hold_if;
    logic w_hold_mem;
    logic w_owner_stall;
    logic w_done;

    assign w_hold_if     = (r_state == ST_HOLD) && !r_owner;
    assign w_hold_mem    = (r_state == ST_HOLD) &&  r_owner;
    assign w_owner_stall = r_owner ? mem_stall_i : if_stall_i;
    assign w_done        = bus_ack_i || (r_cnt == C_CNT_LAST);

    assign if_stallreq_o  = if_ce_i  && !w_hold_if;
    assign mem_stallreq_o = mem_ce_i && !w_hold_mem;
    assign if_data_o      = w_hold_if  ? r_result : 32'd0;
    assign mem_data_o     = w_hold_mem ? r_result : 32'd0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_owner    <= 1'b0;
            r_flushed  <= 1'b0;
            r_cnt      <= '0;
            r_result   <= 32'd0;
            bus_cyc_o  <= 1'b0;
            bus_stb_o  <= 1'b0;
            bus_we_o   <= 1'b0;
            bus_sel_o  <= 4'd0;
            bus_addr_o <= 32'd0;
            bus_data_o <= 32'd0;
            bus_err_o  <= 1'b0;
        end else begin
            bus_err_o <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!flush_i) begin
                        if (mem_ce_i) begin
                            r_owner    <= 1'b1;
                            bus_we_o   <= mem_we_i;
                            bus_sel_o  <= mem_sel_i;
                            bus_addr_o <= mem_addr_i;
                            bus_data_o <= mem_data_i;
                            bus_cyc_o  <= 1'b1;
                            bus_stb_o  <= 1'b1;
                            r_state    <= ST_BUSY;
                        end else if (if_ce_i) begin
                            r_owner    <= 1'b0;
                            bus_we_o   <= 1'b0;
                            bus_sel_o  <= 4'b1111;
                            bus_addr_o <= if_addr_i;
                            bus_data_o <= 32'd0;
                            bus_cyc_o  <= 1'b1;
                            bus_stb_o  <= 1'b1;
                            r_state    <= ST_BUSY;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        bus_cyc_o <= 1'b0;
                        bus_stb_o <= 1'b0;
                        r_cnt     <= '0;
                        if (bus_ack_i) begin
                            bus_we_o <= 1'b0;
                        end else begin
                            bus_err_o <= 1'b1;
                        end
                        // A flush seen at any point in the cycle discards the result
                        if (r_flushed || flush_i) begin
                            r_flushed <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_result <= (bus_ack_i && !bus_we_o) ? bus_data_i : 32'd0;
                            r_state  <= ST_HOLD;
                        end
                    end else begin
                        r_cnt <= r_cnt + C_CNT_ONE;
                        if (flush_i) begin
                            r_flushed <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!w_owner_stall || flush_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
